// File: rtl/lsu_definitions_pkg.sv
// Shared load/store unit definitions: FSM states, exception causes and
// the RV32I funct3 encodings for memory operations.
package lsu_definitions;

    localparam int unsigned BE_W = 4;
    localparam int unsigned RD_W = 5;
    localparam int unsigned F3_W = 3;

    localparam logic [F3_W-1:0] FUNCT3_LB  = 3'b000;
    localparam logic [F3_W-1:0] FUNCT3_LH  = 3'b001;
    localparam logic [F3_W-1:0] FUNCT3_LW  = 3'b010;
    localparam logic [F3_W-1:0] FUNCT3_LBU = 3'b100;
    localparam logic [F3_W-1:0] FUNCT3_LHU = 3'b101;
    localparam logic [F3_W-1:0] FUNCT3_SB  = 3'b000;
    localparam logic [F3_W-1:0] FUNCT3_SH  = 3'b001;
    localparam logic [F3_W-1:0] FUNCT3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } lsu_state_t;

    typedef enum logic [1:0] {
        EXC_NONE        = 2'd0,
        EXC_LD_MISALIGN = 2'd1,
        EXC_ST_MISALIGN = 2'd2,
        EXC_ILLEGAL     = 2'd3
    } lsu_exc_t;

endpackage

// File: rtl/load_store_unit_load_align.sv
// Extracts the addressed byte/half from a read word and sign/zero-extends it.
module lsu_load_align
    import lsu_definitions::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        offset,
    input  logic [F3_W-1:0]   funct3,
    output logic [DATA_W-1:0] data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (offset)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

        data_c = rdata;
        case (funct3)
            FUNCT3_LB:  data_c = {{24{byte_sel[7]}}, byte_sel};
            FUNCT3_LBU: data_c = {24'd0, byte_sel};
            FUNCT3_LH:  data_c = {{16{half_sel[15]}}, half_sel};
            FUNCT3_LHU: data_c = {16'd0, half_sel};
            default:    data_c = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: one load/store per transaction over a req/gnt/rvalid
// port, with alignment checks and load-data extension for writeback.
module load_store_unit
    import lsu_definitions::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_is_load,
    input  logic              ex_is_store,
    input  logic [2:0]        ex_funct3,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic [4:0]        ex_rd,
    output logic              stall_o,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              exc_valid,
    output logic [1:0]        exc_cause,
    output logic [ADDR_W-1:0] exc_addr
);

    lsu_state_t state_q, state_d;

    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [BE_W-1:0]   mem_be_q, mem_be_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              is_load_q, is_load_d;
    logic [F3_W-1:0]   funct3_q, funct3_d;
    logic [1:0]        offset_q, offset_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic              wb_valid_q, wb_valid_d;
    logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              exc_valid_q, exc_valid_d;
    lsu_exc_t          exc_cause_q, exc_cause_d;
    logic [ADDR_W-1:0] exc_addr_q, exc_addr_d;

    logic              illegal;
    logic              misaligned;
    logic [DATA_W-1:0] load_data_c;

    // Decode of the presented operation; illegal takes priority over misaligned.
    always_comb begin
        illegal = (ex_is_load && ex_is_store)
               || (ex_is_load && ((ex_funct3 == 3'b011) || (ex_funct3[2:1] == 2'b11)))
               || (ex_is_store && (ex_funct3 >= 3'b011));
        misaligned = ((ex_funct3 == FUNCT3_LW) && (ex_addr[1:0] != 2'b00))
                  || ((ex_funct3[1:0] == 2'b01) && ex_addr[0]);
    end

    lsu_load_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .rdata  (mem_rdata),
        .offset (offset_q),
        .funct3 (funct3_q),
        .data_c (load_data_c)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        is_load_d   = is_load_q;
        funct3_d    = funct3_q;
        offset_d    = offset_q;
        rd_d        = rd_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        exc_valid_d = 1'b0;
        exc_cause_d = exc_cause_q;
        exc_addr_d  = exc_addr_q;

        case (state_q)
            IDLE: begin
                if (ex_valid && (ex_is_load || ex_is_store)) begin
                    if (illegal || misaligned) begin
                        // Faulting access: report next cycle, never touch memory.
                        exc_valid_d = 1'b1;
                        exc_addr_d  = ex_addr;
                        if (illegal)
                            exc_cause_d = EXC_ILLEGAL;
                        else if (ex_is_load)
                            exc_cause_d = EXC_LD_MISALIGN;
                        else
                            exc_cause_d = EXC_ST_MISALIGN;
                    end else begin
                        state_d    = REQ;
                        mem_req_d  = 1'b1;
                        mem_we_d   = ex_is_store;
                        mem_addr_d = {ex_addr[ADDR_W-1:2], 2'b00};
                        is_load_d  = ex_is_load;
                        funct3_d   = ex_funct3;
                        offset_d   = ex_addr[1:0];
                        rd_d       = ex_rd;
                        mem_be_d   = 4'b1111;
                        if (ex_is_store) begin
                            case (ex_funct3)
                                FUNCT3_SB: begin
                                    mem_be_d    = 4'b0001 << ex_addr[1:0];
                                    mem_wdata_d = {4{ex_wdata[7:0]}};
                                end
                                FUNCT3_SH: begin
                                    mem_be_d    = 4'b0011 << {ex_addr[1], 1'b0};
                                    mem_wdata_d = {2{ex_wdata[15:0]}};
                                end
                                default: begin
                                    mem_be_d    = 4'b1111;
                                    mem_wdata_d = ex_wdata;
                                end
                            endcase
                        end
                    end
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = is_load_q ? WAIT : IDLE;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = load_data_c;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            is_load_q   <= 1'b0;
            funct3_q    <= '0;
            offset_q    <= '0;
            rd_q        <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            exc_valid_q <= 1'b0;
            exc_cause_q <= EXC_NONE;
            exc_addr_q  <= '0;
        end else begin
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            is_load_q   <= is_load_d;
            funct3_q    <= funct3_d;
            offset_q    <= offset_d;
            rd_q        <= rd_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            exc_valid_q <= exc_valid_d;
            exc_cause_q <= exc_cause_d;
            exc_addr_q  <= exc_addr_d;
        end
    end

    assign ex_ready  = (state_q == IDLE);
    assign stall_o   = (state_q != IDLE);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign exc_valid = exc_valid_q;
    assign exc_cause = exc_cause_q;
    assign exc_addr  = exc_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of single transactions
// plus hand-written delayed-handshake and mid-transaction reset sequences.
module tb_load_store_unit;
    import lsu_definitions::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_ready, ex_is_load, ex_is_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_rd;
    logic        stall_o, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic        wb_valid, exc_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, exc_addr;
    logic [1:0]  exc_cause;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
        .stall_o(stall_o),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr)
    );

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  cause;   // 0 = clean access
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic [31:0] wbdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
        ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st;
        ex_funct3 = f3; ex_addr = addr; ex_wdata = wdata; ex_rd = rd;
    endtask

    task automatic release_ex();
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input logic [4:0] rd, input string tag);
        drive(v.ld, v.st, v.f3, v.addr, v.wdata, rd);
        tick();
        release_ex();
        if (v.cause != 2'd0) begin
            chk({tag, " exc_valid"}, exc_valid, 1);
            chk({tag, " exc_cause"}, exc_cause, v.cause);
            chk({tag, " exc_addr"}, exc_addr, v.addr);
            chk({tag, " no mem_req"}, mem_req, 0);
            chk({tag, " ex_ready"}, ex_ready, 1);
            tick();
            chk({tag, " exc pulse end"}, exc_valid, 0);
            chk({tag, " still no mem_req"}, mem_req, 0);
        end else begin
            chk({tag, " mem_req"}, mem_req, 1);
            chk({tag, " mem_we"}, mem_we, v.st);
            chk({tag, " mem_addr"}, mem_addr, v.addr & ~32'd3);
            chk({tag, " mem_be"}, mem_be, v.be);
            if (v.st) chk({tag, " mem_wdata"}, mem_wdata, v.mwdata);
            chk({tag, " stall"}, stall_o, 1);
            mem_gnt = 1'b1;
            tick();
            mem_gnt = 1'b0;
            chk({tag, " req dropped"}, mem_req, 0);
            if (v.st) begin
                chk({tag, " idle after store"}, ex_ready, 1);
            end else begin
                chk({tag, " stall in wait"}, stall_o, 1);
                mem_rvalid = 1'b1;
                mem_rdata  = v.rdata;
                tick();
                mem_rvalid = 1'b0;
                chk({tag, " wb_valid"}, wb_valid, 1);
                chk({tag, " wb_data"}, wb_data, v.wbdata);
                chk({tag, " wb_rd"}, wb_rd, rd);
                chk({tag, " idle after load"}, ex_ready, 1);
                tick();
                chk({tag, " wb pulse end"}, wb_valid, 0);
            end
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic [1:0] cause,
                                input logic [3:0] be, input logic [31:0] mwdata,
                                input logic [31:0] wbdata);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.cause = cause; v.be = be; v.mwdata = mwdata; v.wbdata = wbdata;
        return v;
    endfunction

    vec_t vecs[16];

    initial begin
        vecs[0]  = mk(0, 1, 3'b000, 32'h1003, 32'hAABBCCDD, 32'h0, 2'd0, 4'b1000, 32'hDDDDDDDD, 32'h0);
        vecs[1]  = mk(1, 0, 3'b000, 32'h2001, 32'h0, 32'h00008000, 2'd0, 4'b1111, 32'h0, 32'hFFFFFF80);
        vecs[2]  = mk(1, 0, 3'b100, 32'h2001, 32'h0, 32'h00008000, 2'd0, 4'b1111, 32'h0, 32'h00000080);
        vecs[3]  = mk(1, 0, 3'b010, 32'h3002, 32'h0, 32'h0, 2'd1, 4'b0000, 32'h0, 32'h0);
        vecs[4]  = mk(0, 1, 3'b001, 32'h3001, 32'h0, 32'h0, 2'd2, 4'b0000, 32'h0, 32'h0);
        vecs[5]  = mk(1, 0, 3'b011, 32'h4000, 32'h0, 32'h0, 2'd3, 4'b0000, 32'h0, 32'h0);
        vecs[6]  = mk(1, 1, 3'b010, 32'h4004, 32'h0, 32'h0, 2'd3, 4'b0000, 32'h0, 32'h0);
        vecs[7]  = mk(0, 1, 3'b001, 32'h1002, 32'h12345678, 32'h0, 2'd0, 4'b1100, 32'h56785678, 32'h0);
        vecs[8]  = mk(0, 1, 3'b010, 32'h1004, 32'hCAFEBABE, 32'h0, 2'd0, 4'b1111, 32'hCAFEBABE, 32'h0);
        vecs[9]  = mk(1, 0, 3'b101, 32'h2002, 32'h0, 32'h80010000, 2'd0, 4'b1111, 32'h0, 32'h00008001);
        vecs[10] = mk(1, 0, 3'b010, 32'h2004, 32'h0, 32'hDEADBEEF, 2'd0, 4'b1111, 32'h0, 32'hDEADBEEF);
        vecs[11] = mk(1, 0, 3'b000, 32'h2003, 32'h0, 32'h81000000, 2'd0, 4'b1111, 32'h0, 32'hFFFFFF81);
        vecs[12] = mk(1, 0, 3'b001, 32'h2000, 32'h0, 32'h0000FFFE, 2'd0, 4'b1111, 32'h0, 32'hFFFFFFFE);
        vecs[13] = mk(0, 1, 3'b011, 32'h5000, 32'h0, 32'h0, 2'd3, 4'b0000, 32'h0, 32'h0);
        vecs[14] = mk(1, 0, 3'b110, 32'h5004, 32'h0, 32'h0, 2'd3, 4'b0000, 32'h0, 32'h0);
        vecs[15] = mk(0, 1, 3'b000, 32'h1001, 32'h00000042, 32'h0, 2'd0, 4'b0010, 32'h42424242, 32'h0);

        rst_n = 1'b0;
        release_ex();
        ex_funct3 = 3'b000; ex_addr = '0; ex_wdata = '0; ex_rd = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        tick();
        tick();
        chk("reset ex_ready", ex_ready, 1);
        chk("reset stall", stall_o, 0);
        chk("reset mem_req", mem_req, 0);
        chk("reset mem_be", mem_be, 0);
        chk("reset wb_valid", wb_valid, 0);
        chk("reset exc_valid", exc_valid, 0);
        chk("reset exc_cause", exc_cause, 0);
        chk("reset wb_data", wb_data, 0);
        rst_n = 1'b1;
        tick();

        // Stray gnt/rvalid in IDLE must not start anything.
        mem_gnt = 1'b1; mem_rvalid = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        chk("stray idle wb_valid", wb_valid, 0);
        chk("stray idle ex_ready", ex_ready, 1);

        for (int i = 0; i < 16; i++) begin
            run_vec(vecs[i], 5'(i + 1), $sformatf("vec%0d", i));
        end

        // LH with gnt held off 3 cycles and rvalid 2 cycles after gnt.
        drive(1, 0, 3'b001, 32'h2002, 32'h0, 5'd7);
        tick();
        release_ex();
        for (int i = 0; i < 3; i++) begin
            chk("lh_delay mem_req", mem_req, 1);
            chk("lh_delay mem_addr", mem_addr, 32'h2000);
            chk("lh_delay mem_be", mem_be, 4'b1111);
            chk("lh_delay mem_we", mem_we, 0);
            chk("lh_delay stall", stall_o, 1);
            chk("lh_delay wb_valid", wb_valid, 0);
            mem_rvalid = (i == 1);
            mem_rdata  = 32'h11111111;
            tick();
            mem_rvalid = 1'b0;
        end
        chk("lh_delay req at gnt", mem_req, 1);
        chk("lh_delay no early wb", wb_valid, 0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("lh_delay wait stall", stall_o, 1);
        chk("lh_delay req low", mem_req, 0);
        tick();
        chk("lh_delay wait2 stall", stall_o, 1);
        chk("lh_delay wait2 wb", wb_valid, 0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h80010000;
        tick();
        mem_rvalid = 1'b0;
        chk("lh_delay wb_valid", wb_valid, 1);
        chk("lh_delay wb_data", wb_data, 32'hFFFF8001);
        chk("lh_delay wb_rd", wb_rd, 5'd7);
        chk("lh_delay idle", ex_ready, 1);
        tick();

        // Reset while waiting for read data; the late rvalid must be dropped.
        drive(1, 0, 3'b010, 32'h2008, 32'h0, 5'd9);
        tick();
        release_ex();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("rst_mid in wait", stall_o, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_mid ex_ready", ex_ready, 1);
        chk("rst_mid stall", stall_o, 0);
        chk("rst_mid mem_req", mem_req, 0);
        chk("rst_mid mem_addr", mem_addr, 0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12345678;
        tick();
        mem_rvalid = 1'b0;
        chk("rst_mid late rvalid wb", wb_valid, 0);
        chk("rst_mid late rvalid idle", ex_ready, 1);
        run_vec(mk(1, 0, 3'b010, 32'h200C, 32'h0, 32'h0BADF00D, 2'd0, 4'b1111, 32'h0, 32'h0BADF00D),
                5'd12, "post_reset_lw");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
